// File: rtl/seg7_scan_mux.sv
// Time-multiplexed scan driver for an N-digit packed-BCD display.
// Presents one digit nibble and a one-hot enable per slot; new values take effect at frame wrap.
module seg7_scan_mux #(
    parameter int N_DIGITS = 4,
    parameter int PRESCALE = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    output logic                  busy,
    output logic [3:0]            dec,
    output logic [N_DIGITS-1:0]   digit_en,
    output logic                  frame_tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = $clog2(N_DIGITS);
    localparam int DW = 4 * N_DIGITS;

    localparam logic [CW-1:0]       CNT_MAX = CW'(PRESCALE - 1);
    localparam logic [IW-1:0]       IDX_MAX = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] EN_RST  = N_DIGITS'(1);

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [DW-1:0]       disp_q, disp_d;
    logic [DW-1:0]       pend_q, pend_d;
    logic                pend_valid_q, pend_valid_d;
    logic [3:0]          dec_q, dec_d;
    logic [N_DIGITS-1:0] digit_en_q, digit_en_d;
    logic                frame_tick_q;

    logic                terminal;
    logic                wrap;
    logic [N_DIGITS-1:0] blank_mask;
    logic                zero_above;

    always_comb begin
        terminal = (cnt_q == CNT_MAX);
        wrap     = terminal && (idx_q == IDX_MAX);
    end

    // Prescaler and slot index
    always_comb begin
        cnt_d = terminal ? '0 : cnt_q + CW'(1);
        idx_d = idx_q;
        if (terminal) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        end
    end

    // A load landing on the wrap edge bypasses the pending register entirely.
    always_comb begin
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        if (wrap) begin
            pend_valid_d = 1'b0;
            if (load) begin
                disp_d = bcd_in;
            end else if (pend_valid_q) begin
                disp_d = pend_q;
            end
        end else if (load) begin
            pend_d       = bcd_in;
            pend_valid_d = 1'b1;
        end
    end

    // Digit k>0 is blank when it and every more significant digit are zero.
    always_comb begin
        blank_mask = '0;
        zero_above = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            zero_above    = zero_above && (disp_d[4*k +: 4] == 4'd0);
            blank_mask[k] = BLANK_LZ && zero_above;
        end
    end

    // Outputs follow the next-state index and display so they move on the same edge.
    always_comb begin
        dec_d = blank_mask[idx_d] ? 4'hF : disp_d[{idx_d, 2'b00} +: 4];
        for (int k = 0; k < N_DIGITS; k++) begin
            digit_en_d[k] = (idx_d == IW'(k)) && !blank_mask[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            dec_q        <= 4'd0;
            digit_en_q   <= EN_RST;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            dec_q        <= dec_d;
            digit_en_q   <= digit_en_d;
            frame_tick_q <= wrap;
        end
    end

    assign busy       = pend_valid_q;
    assign dec        = dec_q;
    assign digit_en   = digit_en_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux: one instance with leading-zero blanking, one without,
// both compared every cycle against a frame-level arithmetic model.
module tb_seg7_scan_mux;

    localparam int N     = 4;
    localparam int P     = 4;
    localparam int FRAME = N * P;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] bcd_in;

    logic       busy1, tick1, busy0, tick0;
    logic [3:0] dec1, dec0;
    logic [3:0] en1, en0;

    always #5 clk = ~clk;

    seg7_scan_mux #(.N_DIGITS(N), .PRESCALE(P), .BLANK_LZ(1'b1)) dut_blank (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .bcd_in     (bcd_in),
        .busy       (busy1),
        .dec        (dec1),
        .digit_en   (en1),
        .frame_tick (tick1)
    );

    seg7_scan_mux #(.N_DIGITS(N), .PRESCALE(P), .BLANK_LZ(1'b0)) dut_show (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .bcd_in     (bcd_in),
        .busy       (busy0),
        .dec        (dec0),
        .digit_en   (en0),
        .frame_tick (tick0)
    );

    typedef struct packed {
        logic [3:0] dec1;
        logic [3:0] en1;
        logic [3:0] dec0;
        logic [3:0] en0;
        logic       busy;
        logic       tick;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: edges since reset, shown value, pending value
    int          m_t;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    logic        m_pv;
    logic        m_tick;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, m_t);
    endtask

    task automatic model_reset();
        m_t    = 0;
        m_disp = 16'h0;
        m_pend = 16'h0;
        m_pv   = 1'b0;
        m_tick = 1'b0;
    endtask

    task automatic model_edge(input logic ld, input logic [15:0] v);
        m_t++;
        m_tick = (m_t % FRAME == 0);
        if (m_tick) begin
            if (ld) m_disp = v;
            else if (m_pv) m_disp = m_pend;
            m_pv = 1'b0;
        end else if (ld) begin
            m_pend = v;
            m_pv   = 1'b1;
        end
    endtask

    function automatic exp_t model_expect();
        exp_t        e;
        int          idx;
        logic [15:0] above;
        logic        blank;
        idx    = (m_t / P) % N;
        above  = m_disp >> (4 * idx);
        blank  = (idx > 0) && (above == 16'h0);
        e.dec0 = above[3:0];
        e.en0  = 4'(1 << idx);
        e.dec1 = blank ? 4'hF : above[3:0];
        e.en1  = blank ? 4'h0 : 4'(1 << idx);
        e.busy = m_pv;
        e.tick = m_tick;
        return e;
    endfunction

    task automatic step(input logic r, input logic ld, input logic [15:0] v);
        @(negedge clk);
        rst    = r;
        load   = ld && !r;
        bcd_in = v;
        if (r) model_reset();
        else model_edge(ld, v);
        sb.push_back(model_expect());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'($urandom));
    endtask

    task automatic run_to_phase(input int ph);
        while (((m_t + 1) % FRAME) != ph) step(1'b0, 1'b0, 16'($urandom));
    endtask

    // Reset asserted between edges must clear outputs immediately.
    task automatic reset_now();
        @(negedge clk);
        rst  = 1'b1;
        load = 1'b0;
        model_reset();
        sb.push_back(model_expect());
        #1;
        chk("rst_dec_blank", int'(dec1), 0);
        chk("rst_en_blank", int'(en1), 1);
        chk("rst_busy_blank", int'(busy1), 0);
        chk("rst_tick_blank", int'(tick1), 0);
        chk("rst_dec_show", int'(dec0), 0);
        chk("rst_en_show", int'(en0), 1);
        chk("rst_busy_show", int'(busy0), 0);
        step(1'b1, 1'b0, 16'h0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("dec_blank", int'(dec1), int'(mon_e.dec1));
                chk("en_blank", int'(en1), int'(mon_e.en1));
                chk("dec_show", int'(dec0), int'(mon_e.dec0));
                chk("en_show", int'(en0), int'(mon_e.en0));
                chk("busy_blank", int'(busy1), int'(mon_e.busy));
                chk("busy_show", int'(busy0), int'(mon_e.busy));
                chk("tick_blank", int'(tick1), int'(mon_e.tick));
                chk("tick_show", int'(tick0), int'(mon_e.tick));
            end
        end
    end

    initial begin
        logic        ld;
        logic [15:0] v;
        rst    = 1'b1;
        load   = 1'b0;
        bcd_in = 16'h0;
        model_reset();
        step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);

        // Free-running scan from reset with disp=0
        idle(2 * FRAME + 3);

        // Mid-frame load, shown from the next wrap
        run_to_phase(5);
        step(1'b0, 1'b1, 16'h1234);
        idle(2 * FRAME);

        // Leading-zero blanking
        run_to_phase(3);
        step(1'b0, 1'b1, 16'h0056);
        idle(2 * FRAME);

        // Last of several pending loads wins
        run_to_phase(2);
        step(1'b0, 1'b1, 16'h1111);
        idle(3);
        step(1'b0, 1'b1, 16'h2222);
        idle(2 * FRAME);

        // Load on the wrap edge goes straight to the display
        run_to_phase(0);
        step(1'b0, 1'b1, 16'h9999);
        idle(FRAME + 2);

        // Load on the wrap edge supersedes an earlier pending value
        run_to_phase(7);
        step(1'b0, 1'b1, 16'h4444);
        run_to_phase(0);
        step(1'b0, 1'b1, 16'h0a07);
        idle(FRAME + 2);

        // Reset mid-frame with a pending load discards it
        run_to_phase(9);
        step(1'b0, 1'b1, 16'h5678);
        idle(1);
        reset_now();
        idle(2 * FRAME);

        // Random loads with varying leading zeros and occasional resets
        for (int i = 0; i < 900; i++) begin
            ld = ($urandom_range(0, 7) == 0);
            v  = 16'($urandom) >> (4 * $urandom_range(0, 4));
            if ($urandom_range(0, 299) == 0) reset_now();
            else step(1'b0, ld, v);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
